adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Sequences the board's multiplexed serial ADC, driving AD_SEL0..7, AD_CNVST_N and AD_SCLK and capturing AD_SDOUT. It scans the enabled mux channels in ascending order and delivers one 16-bit sample per channel as a single-cycle result strobe. It sits in top_app between the ADC pins and the application logic, replacing the tie-offs currently on those outputs.

## Interface
- NUM_CH, 8, number of mux channels; ad_sel width.
- DATA_W, 16, ADC result width, shifted MSB first.
- SETTLE_CYCLES, 50, mux settle time in clk cycles; minimum 1.
- CONV_CYCLES, 100, conversion wait after the CNVST pulse; minimum 1.
- SCLK_DIV, 4, clk cycles per SCLK half-period; minimum 1.
- CLK_100M  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- scan_en  in  1  level; high = keep scanning passes.
- ch_mask  in  NUM_CH  channel enables; bit i = channel i.
- ad_sdout  in  1  ADC serial data.
- ad_sclk  out  1  ADC serial clock; idles low.
- ad_cnvst_n  out  1  conversion start, active low; idles high.
- ad_sel  out  NUM_CH  one-hot mux select; all zero when idle.
- busy  out  1  high while a pass is in progress.
- result_valid  out  1  one-cycle strobe; result fields valid.
- result_ch  out  3  channel of the result.
- result_data  out  DATA_W  sample.
- scan_done  out  1  one-cycle strobe; a pass completed.

## Operation
- All outputs are registered. Reset values: ad_sclk=0, ad_cnvst_n=1, ad_sel=0, busy=0, result_valid=0, result_ch=0, result_data=0, scan_done=0. On reset the FSM returns to IDLE.
- States: IDLE, SETTLE, CNV, WAIT, SHIFT, DONE.
- IDLE: if scan_en=1 and ch_mask!=0, latch ch_mask into pass_mask, select the lowest set bit, then go to SETTLE with busy=1. Otherwise stay in IDLE.
- SETTLE: ad_sel is one-hot for the current channel; count SETTLE_CYCLES, then go to CNV.
- CNV: ad_cnvst_n=0 for exactly 2 cycles, then go to WAIT.
- WAIT: count CONV_CYCLES, then go to SHIFT.
- SHIFT: DATA_W SCLK periods. Each period is SCLK_DIV cycles low followed by SCLK_DIV cycles high. ad_sdout is sampled into the shift register on the clk edge where ad_sclk is driven 0→1, MSB first. After the last high phase, ad_sclk=0 and the FSM goes to DONE.
- DONE (1 cycle): result_valid=1, result_ch=current channel, result_data=shift register. result_data and result_ch hold their values until the next result.
- After DONE:
  - If pass_mask has a higher set bit and scan_en=1, go to SETTLE on that channel. ad_sel switches directly, with no all-zero gap.
  - If no higher bit remains, assert scan_done for 1 cycle (the cycle after DONE), clear busy, and go to IDLE. ad_sel becomes 0.
  - If scan_en=0, go to IDLE with no scan_done.
- scan_en falling mid-channel: the current channel completes through DONE, then the block stops (abort; no scan_done).
- ch_mask changes mid-pass are ignored; pass_mask is sampled only when leaving IDLE.
- Restart after scan_done: IDLE costs 1 cycle, then a new pass starts if scan_en=1.
- Reset mid-operation: outputs return to reset values immediately. No partial result is emitted.

## Timing
- Cycle 0 is the first SETTLE cycle. Schedule per channel:
  - CNV occupies cycles S and S+1, where S=SETTLE_CYCLES.
  - WAIT lasts CONV_CYCLES.
  - SHIFT lasts 2·SCLK_DIV·DATA_W cycles.
  - result_valid is asserted at cycle S+2+CONV_CYCLES+2·SCLK_DIV·DATA_W. With the defaults this is cycle 280.
- Channel-to-channel period: that value + 1 (the DONE cycle). With the defaults this is 281.
- First SETTLE cycle occurs 1 cycle after scan_en=1 is seen in IDLE.
- Bit k of the sample (k=DATA_W-1 first) is taken on the (DATA_W-k)-th SCLK rising edge.

## Test plan
- ch_mask=0x01, scan_en=1; ADC model returns 0xA5C3 -> result_valid at cycle 280 with result_ch=0, result_data=0xA5C3; scan_done at cycle 281; exactly 16 SCLK pulses; CNVST low for 2 cycles.
- ch_mask=0x81, ADC returns 0x1234 on ch0 and 0xFEDC on ch7 -> results in order ch0 then ch7, 281 cycles apart; ad_sel goes 0x01 then 0x80; single scan_done after ch7.
- ch_mask=0x00, scan_en=1 for 1000 cycles -> busy=0, ad_sel=0, no SCLK or CNVST activity, no strobes.
- ch_mask=0xFF; drop scan_en during ch2 WAIT -> ch2 result delivered, then IDLE, no scan_done, ad_sel=0.
- Change ch_mask from 0x0F to 0xF0 during ch1 -> pass still delivers ch2 and ch3; next pass scans ch4..ch7.
- Assert rst during SHIFT of ch3 -> same cycle ad_sclk=0, ad_cnvst_n=1, ad_sel=0, busy=0; no result_valid; after release with scan_en=1 the scan restarts at the lowest enabled channel.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans enabled ADC mux channels in ascending order, one serial sample per channel
module adc_scan_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 50,
    parameter int CONV_CYCLES   = 100,
    parameter int SCLK_DIV      = 4
) (
    input  logic              CLK_100M,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              ad_sdout,
    output logic              ad_sclk,
    output logic              ad_cnvst_n,
    output logic [NUM_CH-1:0] ad_sel,
    output logic              busy,
    output logic              result_valid,
    output logic [2:0]        result_ch,
    output logic [DATA_W-1:0] result_data,
    output logic              scan_done
);
    localparam int SHIFT_LEN = 2 * SCLK_DIV * DATA_W;
    localparam int CNT_MAX = (SHIFT_LEN > SETTLE_CYCLES) ?
        ((SHIFT_LEN > CONV_CYCLES) ? SHIFT_LEN : CONV_CYCLES) :
        ((SETTLE_CYCLES > CONV_CYCLES) ? SETTLE_CYCLES : CONV_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CNV, WAIT, SHIFT, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n, half;
    logic [2:0]         ch, ch_n, first, nxt;
    logic [NUM_CH-1:0]  pass_mask, mask_n, sel_n;
    logic [DATA_W-1:0]  shreg;
    logic               found, sclk_n, cnvst_n_n, busy_n, rv_n, sd_n;

    // State, counters and all outputs are registered from the next-state decode
    always_ff @(posedge CLK_100M or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ch           <= '0;
            pass_mask    <= '0;
            shreg        <= '0;
            ad_sclk      <= 1'b0;
            ad_cnvst_n   <= 1'b1;
            ad_sel       <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            scan_done    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ch           <= ch_n;
            pass_mask    <= mask_n;
            ad_sclk      <= sclk_n;
            ad_cnvst_n   <= cnvst_n_n;
            ad_sel       <= sel_n;
            busy         <= busy_n;
            result_valid <= rv_n;
            scan_done    <= sd_n;
            if (sclk_n && !ad_sclk)
                shreg <= {shreg[DATA_W-2:0], ad_sdout};
            if (rv_n) begin
                result_ch   <= ch;
                result_data <= shreg;
            end
        end
    end

    // Next state: phase counter per state, lowest channel on start, next higher channel after DONE
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        ch_n    = ch;
        mask_n  = pass_mask;
        first   = '0;
        nxt     = ch;
        found   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (ch_mask[i]) first = 3'(i);
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pass_mask[i] && 3'(i) > ch) begin
                nxt   = 3'(i);
                found = 1'b1;
            end
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (scan_en && |ch_mask) begin
                    state_n = SETTLE;
                    ch_n    = first;
                    mask_n  = ch_mask;
                end
            end
            SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin state_n = CNV;   cnt_n = '0; end
            CNV:    if (cnt == CNT_W'(1))                 begin state_n = WAIT;  cnt_n = '0; end
            WAIT:   if (cnt == CNT_W'(CONV_CYCLES - 1))   begin state_n = SHIFT; cnt_n = '0; end
            SHIFT:  if (cnt == CNT_W'(SHIFT_LEN - 1))     begin state_n = DONE;  cnt_n = '0; end
            DONE: begin
                cnt_n   = '0;
                state_n = (found && scan_en) ? SETTLE : IDLE;
                ch_n    = (found && scan_en) ? nxt : ch;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode of the upcoming state; SCLK is high in the odd SCLK_DIV-long slots of SHIFT
    always_comb begin
        half      = cnt_n / CNT_W'(SCLK_DIV);
        sclk_n    = (state_n == SHIFT) && half[0];
        cnvst_n_n = state_n != CNV;
        sel_n     = (state_n == IDLE) ? '0 : NUM_CH'(1) << ch_n;
        busy_n    = state_n != IDLE;
        rv_n      = state_n == DONE;
        sd_n      = (state == DONE) && !found && scan_en;
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: timeline model of the scan plus directed scenarios for adc_scan_sequencer
module tb_adc_scan_sequencer;
    localparam int S  = 50;
    localparam int C  = 100;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int SH0 = S + 2 + C;
    localparam int TD = SH0 + 2 * D * W;

    logic        CLK_100M = 1'b0;
    logic        rst = 1'b1;
    logic        scan_en = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic        ad_sdout = 1'b0;
    logic        ad_sclk, ad_cnvst_n, busy, result_valid, scan_done;
    logic [7:0]  ad_sel;
    logic [2:0]  result_ch;
    logic [15:0] result_data;

    adc_scan_sequencer dut (
        .CLK_100M(CLK_100M), .rst(rst), .scan_en(scan_en), .ch_mask(ch_mask),
        .ad_sdout(ad_sdout), .ad_sclk(ad_sclk), .ad_cnvst_n(ad_cnvst_n),
        .ad_sel(ad_sel), .busy(busy), .result_valid(result_valid),
        .result_ch(result_ch), .result_data(result_data), .scan_done(scan_done)
    );

    always #5 CLK_100M = ~CLK_100M;

    int n_chk = 0, n_err = 0;
    logic [15:0] adc_val [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ADC device: loads the addressed channel's word on CNVST fall, presents next bit after each SCLK rise
    initial begin
        int idx;
        logic [15:0] w;
        idx = 0;
        w = '0;
        forever begin
            @(negedge ad_cnvst_n or posedge ad_sclk);
            if (ad_sclk) begin
                if (idx > 0) idx--;
            end else begin
                w = '0;
                for (int i = 0; i < 8; i++) if (ad_sel[i]) w = adc_val[i];
                idx = 15;
            end
            ad_sdout = w[idx];
        end
    end

    // Reference model: position within a channel's fixed timeline
    logic        m_act = 1'b0, m_sd = 1'b0;
    logic [7:0]  m_pm = '0;
    int          m_ch = 0, m_t = 0, m_rch = 0;
    logic [15:0] m_rdata = '0;

    always @(posedge CLK_100M or posedge rst) begin
        int nx;
        if (rst) begin
            m_act = 0; m_sd = 0; m_ch = 0; m_t = 0; m_rch = 0; m_rdata = '0;
        end else begin
            m_sd = 0;
            if (!m_act) begin
                if (scan_en && ch_mask != 0) begin
                    m_act = 1; m_pm = ch_mask; m_t = 0; m_ch = 0;
                    while (!m_pm[m_ch]) m_ch++;
                end
            end else if (m_t == TD) begin
                nx = -1;
                for (int i = 7; i > m_ch; i--) if (m_pm[i]) nx = i;
                if (nx >= 0 && scan_en) begin m_ch = nx; m_t = 0; end
                else begin m_act = 0; m_sd = (nx < 0) && scan_en; end
            end else m_t++;
            if (m_act && m_t == TD) begin m_rch = m_ch; m_rdata = adc_val[m_ch]; end
        end
    end

    // Per-cycle comparison against the model plus activity statistics
    int cyc = 0, start_c = 0, n_sclk = 0, n_cnv = 0, n_sel = 0, n_sd = 0, sd_t = 0;
    int rv_q[$], rv_t[$];
    logic busy_q = 0, sclk_q = 0;

    always @(negedge CLK_100M) begin
        cyc++;
        if (!rst) begin
            chk("ad_sel", ad_sel, m_act ? 8'(1 << m_ch) : 8'h00);
            chk("busy", busy, m_act);
            chk("ad_cnvst_n", ad_cnvst_n, !(m_act && (m_t == S || m_t == S + 1)));
            chk("ad_sclk", ad_sclk, m_act && m_t >= SH0 && m_t < TD && (((m_t - SH0) / D) % 2 == 1));
            chk("result_valid", result_valid, m_act && m_t == TD);
            chk("scan_done", scan_done, m_sd);
            chk("result_ch", result_ch, m_rch);
            chk("result_data", result_data, m_rdata);
            if (busy && !busy_q) start_c = cyc;
            if (ad_sclk && !sclk_q) n_sclk++;
            if (!ad_cnvst_n) n_cnv++;
            if (ad_sel != 0) n_sel++;
            if (result_valid) begin rv_q.push_back(result_ch); rv_t.push_back(cyc - start_c); end
            if (scan_done) begin n_sd++; sd_t = cyc - start_c; end
        end
        busy_q = busy;
        sclk_q = ad_sclk;
    end

    task automatic clr();
        n_sclk = 0; n_cnv = 0; n_sel = 0; n_sd = 0; sd_t = 0;
        rv_q.delete(); rv_t.delete();
    endtask

    task automatic wait_busy(input int lim);
        int k;
        k = 0;
        do begin @(negedge CLK_100M); k++; end while (!busy && k < lim);
        if (!busy) chk("wait_busy_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        do begin @(negedge CLK_100M); k++; end while (busy && k < lim);
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_sd(input int lim, input logic drop);
        int k;
        k = 0;
        do begin @(negedge CLK_100M); k++; end while (!scan_done && k < lim);
        if (!scan_done) chk("wait_scan_done_timeout", 0, 1);
        if (drop) scan_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 16'h1111 * 16'(i);
        repeat (3) @(negedge CLK_100M);
        chk("rst_sclk", ad_sclk, 0);
        chk("rst_cnvst_n", ad_cnvst_n, 1);
        chk("rst_sel", ad_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_data", result_data, 0);
        rst = 1'b0;

        // Single channel 0
        clr();
        adc_val[0] = 16'hA5C3;
        ch_mask = 8'h01; scan_en = 1'b1;
        wait_sd(2000, 1'b1);
        wait_idle(10);
        chk("t1_nres", rv_q.size(), 1);
        if (rv_q.size() == 1) begin
            chk("t1_ch", rv_q[0], 0);
            chk("t1_rv_cycle", rv_t[0], 280);
        end
        chk("t1_sd_cycle", sd_t, 281);
        chk("t1_nsd", n_sd, 1);
        chk("t1_sclk_pulses", n_sclk, 16);
        chk("t1_cnv_cycles", n_cnv, 2);
        chk("t1_data", result_data, 16'hA5C3);

        // Channels 0 and 7
        clr();
        adc_val[0] = 16'h1234; adc_val[7] = 16'hFEDC;
        ch_mask = 8'h81; scan_en = 1'b1;
        wait_sd(2000, 1'b1);
        wait_idle(10);
        chk("t2_nres", rv_q.size(), 2);
        if (rv_q.size() == 2) begin
            chk("t2_ch_a", rv_q[0], 0);
            chk("t2_ch_b", rv_q[1], 7);
            chk("t2_gap", rv_t[1] - rv_t[0], 281);
        end
        chk("t2_nsd", n_sd, 1);
        chk("t2_data", result_data, 16'hFEDC);

        // Empty mask: no activity
        clr();
        ch_mask = 8'h00; scan_en = 1'b1;
        repeat (1000) @(negedge CLK_100M);
        chk("t3_sclk", n_sclk, 0);
        chk("t3_cnv", n_cnv, 0);
        chk("t3_sel", n_sel, 0);
        chk("t3_nres", rv_q.size(), 0);
        chk("t3_nsd", n_sd, 0);
        chk("t3_busy", busy, 0);
        scan_en = 1'b0;

        // Abort during channel 2 WAIT
        clr();
        ch_mask = 8'hFF; scan_en = 1'b1;
        wait_busy(10);
        repeat (2 * 281 + 100) @(negedge CLK_100M);
        scan_en = 1'b0;
        wait_idle(1000);
        chk("t4_nres", rv_q.size(), 3);
        chk("t4_last_ch", result_ch, 2);
        chk("t4_data", result_data, 16'h2222);
        chk("t4_nsd", n_sd, 0);
        chk("t4_sel", ad_sel, 0);

        // Mask change mid-pass applies only to the next pass
        clr();
        ch_mask = 8'h0F; scan_en = 1'b1;
        wait_busy(10);
        repeat (281 + 20) @(negedge CLK_100M);
        ch_mask = 8'hF0;
        wait_sd(3000, 1'b0);
        wait_sd(3000, 1'b1);
        wait_idle(10);
        chk("t5_nres", rv_q.size(), 8);
        for (int i = 0; i < 8 && i < rv_q.size(); i++) chk("t5_order", rv_q[i], i);
        chk("t5_nsd", n_sd, 2);

        // Reset during channel 3 SHIFT
        clr();
        ch_mask = 8'hFF; scan_en = 1'b1;
        wait_busy(10);
        repeat (3 * 281 + SH0 + 50) @(negedge CLK_100M);
        @(posedge CLK_100M);
        #2 rst = 1'b1;
        #1;
        chk("t6_sclk", ad_sclk, 0);
        chk("t6_cnvst_n", ad_cnvst_n, 1);
        chk("t6_sel", ad_sel, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rv", result_valid, 0);
        chk("t6_nres_before", rv_q.size(), 3);
        repeat (3) @(negedge CLK_100M);
        rst = 1'b0;
        clr();
        wait_busy(10);
        repeat (10) @(negedge CLK_100M);
        scan_en = 1'b0;
        wait_idle(1000);
        chk("t6_nres_after", rv_q.size(), 1);
        if (rv_q.size() == 1) chk("t6_restart_ch", rv_q[0], 0);
        chk("t6_data", result_data, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
